// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types and constants for the bit-serial adder/subtractor
package serial_addsub_pkg;

  // Sequencer states: waiting for operands, shifting bits, holding a result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Operation encoding on op_sub
  localparam logic SA_OP_ADD = 1'b0;
  localparam logic SA_OP_SUB = 1'b1;

  // Default operand width
  localparam int SA_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - start/result handshake bundle for serial_addsub
interface serial_addsub_if
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
);

  // Operation request channel
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op_sub;

  // Result channel
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  // Requester side: offers operations, consumes results
  modport master (
    output start_valid, a_in, b_in, op_sub, res_ready,
    input  start_ready, res_valid, result, cout, ovf
  );

  // Arithmetic block side
  modport slave (
    input  start_valid, a_in, b_in, op_sub, res_ready,
    output start_ready, res_valid, result, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_fas1bit.sv
// rtl/serial_addsub_fas1bit.sv - one-bit full adder/subtractor cell
module fas1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  input  logic s_op_i,
  output logic s_o,
  output logic cout_o
);

  // In subtract mode B is inverted; the +1 comes in through the carry
  logic b_eff;

  // Sum and majority carry of a, effective b and carry-in
  always_comb begin
    b_eff  = b_i ^ s_op_i;
    s_o    = a_i ^ b_eff ^ cin_i;
    cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);
  end

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - LSB-first bit-serial adder/subtractor; SERIAL_ADDSUB_OVF_EN enables the ovf flag
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  // Bit counter only has to reach WIDTH-1
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_c_q, ovf_c_d;
`endif

  logic             accept;
  logic             start_ready_c;
  logic             cell_s;
  logic             cell_cout;

  // The single arithmetic cell, fed from the LSBs of the operand shifters
  fas1bit u_cell (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (carry_q),
    .s_op_i (op_q),
    .s_o    (cell_s),
    .cout_o (cell_cout)
  );

  // Next-state and datapath control; results land in output regs only on the last bit
  always_comb begin
    state_d       = state_q;
    a_sr_d        = a_sr_q;
    b_sr_d        = b_sr_q;
    res_sr_d      = res_sr_q;
    result_d      = result_q;
    op_d          = op_q;
    carry_d       = carry_q;
    cout_d        = cout_q;
    cnt_d         = cnt_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_c_d       = ovf_c_q;
`endif
    accept        = 1'b0;
    start_ready_c = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready_c = 1'b1;
        accept        = bus.start_valid;
      end

      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = {cell_s, res_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB
          result_d = {cell_s, res_sr_q[WIDTH-1:1]};
          cout_d   = cell_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_c_d  = carry_q;
`endif
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          start_ready_c = 1'b1;
          accept        = bus.start_valid;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // New operation: carry preset to 1 on subtract supplies the two's complement +1
    if (accept) begin
      a_sr_d   = bus.a_in;
      b_sr_d   = bus.b_in;
      op_d     = bus.op_sub;
      carry_d  = (bus.op_sub == SA_OP_SUB);
      cnt_d    = '0;
      res_sr_d = '0;
      state_d  = RUN;
    end
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      result_q <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_c_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_c_q  <= ovf_c_d;
`endif
    end
  end

  assign bus.start_ready = start_ready_c;
  assign bus.res_valid   = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.cout        = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  // Signed overflow: carry into MSB differs from carry out of MSB
  assign bus.ovf         = ovf_c_q ^ cout_q;
`else
  assign bus.ovf         = 1'b0;
`endif

endmodule
